// File: rtl/uart_rx_top.sv
// UART16550 receiver: 16x oversampled deserialiser for 5-8 data bits, optional parity and one stop bit.
// Define UART_RX_SYNC_EN to pass rx through a 2-flop synchroniser before the receive FSM.
module uart_rx_top #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_pulse,
    input  logic       rx,
    input  logic       pen,
    input  logic       eps,
    input  logic       stick_parity,
    input  logic [1:0] wls,
    output logic [7:0] rx_out,
    output logic       push,
    output logic       pe,
    output logic       fe,
    output logic       bi,
    output logic       rx_busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] MID_TICK  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t          state_q;
    logic [TW-1:0]   tick_q;
    logic [2:0]      bitcnt_q;
    logic [7:0]      data_q;
    logic            par_q;
    logic            pen_q;
    logic            eps_q;
    logic            stick_q;
    logic [1:0]      wls_q;
    logic            armed_q;
    logic [7:0]      rx_out_q;
    logic            push_q;
    logic            pe_q;
    logic            fe_q;
    logic            bi_q;
    logic            busy_q;

    logic            rx_s;
    logic            par_exp;
    logic            last_bit;
    logic            end_tick;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx};
        end
    end

    assign rx_s = sync_q[1];
`else
    assign rx_s = rx;
`endif

    // Upper data bits are cleared when a frame starts, so full-width parity is exact for short words.
    assign par_exp  = stick_q ? ~eps_q : (eps_q ? ^data_q : ~^data_q);
    assign last_bit = (bitcnt_q == ({1'b0, wls_q} + 3'd4));
    assign end_tick = (tick_q == LAST_TICK);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            tick_q   <= '0;
            bitcnt_q <= '0;
            data_q   <= '0;
            par_q    <= 1'b0;
            pen_q    <= 1'b0;
            eps_q    <= 1'b0;
            stick_q  <= 1'b0;
            wls_q    <= 2'b00;
            armed_q  <= 1'b1;
            rx_out_q <= '0;
            push_q   <= 1'b0;
            pe_q     <= 1'b0;
            fe_q     <= 1'b0;
            bi_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            push_q <= 1'b0;
            if (baud_pulse) begin
                unique case (state_q)
                    IDLE: begin
                        tick_q <= '0;
                        // After a framing error the line must be seen high before a new start is accepted.
                        if (!armed_q) begin
                            armed_q <= rx_s;
                        end else if (!rx_s) begin
                            state_q <= START;
                            busy_q  <= 1'b1;
                        end
                    end
                    START: begin
                        if (tick_q == MID_TICK) begin
                            tick_q <= '0;
                            if (rx_s) begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q  <= DATA;
                                bitcnt_q <= '0;
                                data_q   <= '0;
                                par_q    <= 1'b0;
                                pen_q    <= pen;
                                eps_q    <= eps;
                                stick_q  <= stick_parity;
                                wls_q    <= wls;
                            end
                        end else begin
                            tick_q <= tick_q + 1'b1;
                        end
                    end
                    DATA: begin
                        if (end_tick) begin
                            tick_q           <= '0;
                            data_q[bitcnt_q] <= rx_s;
                            bitcnt_q         <= bitcnt_q + 1'b1;
                            if (last_bit) begin
                                state_q <= pen_q ? PARITY : STOP;
                            end
                        end else begin
                            tick_q <= tick_q + 1'b1;
                        end
                    end
                    PARITY: begin
                        if (end_tick) begin
                            tick_q  <= '0;
                            par_q   <= rx_s;
                            state_q <= STOP;
                        end else begin
                            tick_q <= tick_q + 1'b1;
                        end
                    end
                    STOP: begin
                        if (end_tick) begin
                            tick_q   <= '0;
                            state_q  <= IDLE;
                            busy_q   <= 1'b0;
                            push_q   <= 1'b1;
                            rx_out_q <= data_q;
                            pe_q     <= pen_q & (par_q != par_exp);
                            fe_q     <= ~rx_s;
                            bi_q     <= ~rx_s & (data_q == 8'd0) & (~par_q | ~pen_q);
                            armed_q  <= rx_s;
                        end else begin
                            tick_q <= tick_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rx_out  = rx_out_q;
    assign push    = push_q;
    assign pe      = pe_q;
    assign fe      = fe_q;
    assign bi      = bi_q;
    assign rx_busy = busy_q;

endmodule

// File: tb/tb_uart_rx_top.sv
// Testbench for uart_rx_top: directed frames with a frame-level scoreboard checked every clock.
module tb_uart_rx_top;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       baud_pulse = 1'b0;
    logic       rx = 1'b1;
    logic       pen = 1'b0;
    logic       eps = 1'b0;
    logic       stickParity = 1'b0;
    logic [1:0] wls = 2'b11;
    logic [7:0] rxOut;
    logic       push;
    logic       pe;
    logic       fe;
    logic       bi;
    logic       rxBusy;

    int total = 0;
    int bad = 0;
    logic testDone = 1'b0;

    typedef struct packed {
        logic [7:0] data;
        logic       pe;
        logic       fe;
        logic       bi;
    } expRec_t;

    expRec_t expQ[$];
    expRec_t lastExp = '0;

    uart_rx_top dut (
        .clk          (clk),
        .rst          (rst),
        .baud_pulse   (baud_pulse),
        .rx           (rx),
        .pen          (pen),
        .eps          (eps),
        .stick_parity (stickParity),
        .wls          (wls),
        .rx_out       (rxOut),
        .push         (push),
        .pe           (pe),
        .fe           (fe),
        .bi           (bi),
        .rx_busy      (rxBusy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // What a frame must decode to, from the wire-level bits and the line settings.
    function automatic expRec_t modelFrame(input logic [7:0] data, input int nBits, input logic parOn,
                                           input logic evenSel, input logic stick, input logic parBit,
                                           input logic stopBit);
        expRec_t r;
        int      mask;
        int      ones;
        logic    expPar;
        mask   = (1 << nBits) - 1;
        r.data = data & mask[7:0];
        ones   = $countones(r.data);
        if (stick) expPar = !evenSel;
        else if (evenSel) expPar = (ones % 2 == 1);
        else expPar = (ones % 2 == 0);
        r.pe = parOn && (parBit != expPar);
        r.fe = !stopBit;
        r.bi = !stopBit && (r.data == 8'd0) && (!parOn || !parBit);
        return r;
    endfunction

    task automatic oneTick();
        @(negedge clk) baud_pulse = 1'b1;
        @(negedge clk) baud_pulse = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic sendBit(input logic b, input int n);
        rx = b;
        repeat (n) oneTick();
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic parBit, input logic stopBit,
                                 input bit scramble);
        int   nBits;
        logic parOn;
        nBits = int'(wls) + 5;
        parOn = pen;
        expQ.push_back(modelFrame(data, nBits, pen, eps, stickParity, parBit, stopBit));
        sendBit(1'b0, 16);
        // Settings changed after the start bit must not affect this frame.
        if (scramble) begin
            wls = ~wls;
            pen = ~pen;
            eps = ~eps;
        end
        for (int i = 0; i < nBits; i++) sendBit(data[i], 16);
        if (parOn) sendBit(parBit, 16);
        sendBit(stopBit, 16);
    endtask

    // Scoreboard: every cycle, a push must match the next expected frame and outputs must hold otherwise.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                expQ.delete();
                lastExp = '0;
            end
            if (push === 1'b1) begin
                if (expQ.size() == 0) checkOutput("unexpected push", push, 0);
                else lastExp = expQ.pop_front();
            end
            checkOutput("sb rx_out", rxOut, lastExp.data);
            checkOutput("sb pe", pe, lastExp.pe);
            checkOutput("sb fe", fe, lastExp.fe);
            checkOutput("sb bi", bi, lastExp.bi);
        end
    end

    initial begin
        #900000;
        checkOutput("watchdog done", testDone, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        expRec_t m;
        $display("[TB] start");
        repeat (3) @(negedge clk);
        checkOutput("reset rx_out", rxOut, 8'h00);
        checkOutput("reset push", push, 0);
        checkOutput("reset fe", fe, 0);
        checkOutput("reset busy", rxBusy, 0);
        rst = 1'b1;
        sendBit(1'b1, 32);

        m = modelFrame(8'h13, 8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("model bad parity", m, {8'h13, 1'b1, 1'b0, 1'b0});
        m = modelFrame(8'h00, 8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("model break", m, {8'h00, 1'b0, 1'b1, 1'b1});

        wls = 2'b11; pen = 1'b1; eps = 1'b1; stickParity = 1'b0;
        applyStimulus(8'h13, 1'b1, 1'b1, 1'b0);
        sendBit(1'b1, 4);
        checkOutput("t1 rx_out", rxOut, 8'h13);
        checkOutput("t1 pe", pe, 0);
        checkOutput("t1 busy", rxBusy, 0);

        applyStimulus(8'h13, 1'b0, 1'b1, 1'b0);
        sendBit(1'b1, 4);
        checkOutput("t2 rx_out", rxOut, 8'h13);
        checkOutput("t2 pe", pe, 1);

        wls = 2'b00; pen = 1'b0;
        applyStimulus(8'h15, 1'b0, 1'b1, 1'b1);
        sendBit(1'b1, 4);
        checkOutput("t3 rx_out", rxOut, 8'h15);
        checkOutput("t3 pe", pe, 0);

        wls = 2'b11; pen = 1'b1; eps = 1'b1; stickParity = 1'b0;
        applyStimulus(8'h13, 1'b1, 1'b0, 1'b0);
        checkOutput("t4 fe", fe, 1);
        checkOutput("t4 bi", bi, 0);
        sendBit(1'b1, 16);
        expQ.push_back(modelFrame(8'h00, 8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        sendBit(1'b0, 3 * 11 * 16);
        checkOutput("t4 break pending", expQ.size(), 0);
        checkOutput("t4 break rx_out", rxOut, 8'h00);
        checkOutput("t4 break bi", bi, 1);
        checkOutput("t4 break busy", rxBusy, 0);
        sendBit(1'b1, 32);

        sendBit(1'b0, 4);
        checkOutput("t5 busy in start", rxBusy, 1);
        sendBit(1'b1, 16);
        checkOutput("t5 busy after", rxBusy, 0);

        wls = 2'b11; pen = 1'b1; eps = 1'b0;
        sendBit(1'b0, 16);
        sendBit(1'b1, 16);
        sendBit(1'b1, 16);
        sendBit(1'b0, 16);
        sendBit(1'b0, 8);
        @(negedge clk) rst = 1'b0;
        @(negedge clk) rst = 1'b1;
        checkOutput("t6 rx_out", rxOut, 8'h00);
        checkOutput("t6 fe", fe, 0);
        checkOutput("t6 bi", bi, 0);
        checkOutput("t6 push", push, 0);
        checkOutput("t6 busy", rxBusy, 0);
        sendBit(1'b1, 32);
        applyStimulus(8'hA5, 1'b1, 1'b1, 1'b0);
        sendBit(1'b1, 4);
        checkOutput("t6 a5 rx_out", rxOut, 8'hA5);
        checkOutput("t6 a5 pe", pe, 0);

        wls = 2'b01; pen = 1'b1; eps = 1'b1; stickParity = 1'b1;
        applyStimulus(8'hEA, 1'b1, 1'b1, 1'b0);
        sendBit(1'b1, 4);
        checkOutput("t7 rx_out", rxOut, 8'h2A);
        checkOutput("t7 pe", pe, 1);

        wls = 2'b10; pen = 1'b1; eps = 1'b0; stickParity = 1'b0;
        applyStimulus(8'h7F, 1'b0, 1'b1, 1'b0);
        applyStimulus(8'h00, 1'b1, 1'b1, 1'b0);
        sendBit(1'b1, 4);
        checkOutput("t8 rx_out", rxOut, 8'h00);
        checkOutput("t8 pe", pe, 0);

        checkOutput("pending pushes", expQ.size(), 0);
        testDone = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
